// File: rtl/axi_rd_arbiter_if.sv
// Bus bundle for axi_rd_arbiter: two requester ports plus the shared AXI4 AR/R channel.
// The master modport is the arbiter's view; slave is the surrounding requesters and AXI slave.
interface axi_rd_arbiter_if #(
  parameter int C_M_AXI_ADDR_WIDTH      = 32,
  parameter int C_M_AXI_DATA_WIDTH      = 32,
  parameter int C_M_AXI_THREAD_ID_WIDTH = 1
);
  logic                               R0_REQ;
  logic [C_M_AXI_ADDR_WIDTH-1:0]      R0_ADDR;
  logic [7:0]                         R0_LEN;
  logic                               R0_GNT;
  logic                               R0_RREADY;
  logic                               R0_RVALID;
  logic [C_M_AXI_DATA_WIDTH-1:0]      R0_RDATA;
  logic                               R0_RLAST;
  logic                               R0_DONE;
  logic                               R0_ERR;

  logic                               R1_REQ;
  logic [C_M_AXI_ADDR_WIDTH-1:0]      R1_ADDR;
  logic [7:0]                         R1_LEN;
  logic                               R1_GNT;
  logic                               R1_RREADY;
  logic                               R1_RVALID;
  logic [C_M_AXI_DATA_WIDTH-1:0]      R1_RDATA;
  logic                               R1_RLAST;
  logic                               R1_DONE;
  logic                               R1_ERR;

  logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_ARID;
  logic [C_M_AXI_ADDR_WIDTH-1:0]      M_AXI_ARADDR;
  logic [7:0]                         M_AXI_ARLEN;
  logic [2:0]                         M_AXI_ARSIZE;
  logic [1:0]                         M_AXI_ARBURST;
  logic                               M_AXI_ARLOCK;
  logic [3:0]                         M_AXI_ARCACHE;
  logic [2:0]                         M_AXI_ARPROT;
  logic [3:0]                         M_AXI_ARQOS;
  logic                               M_AXI_ARUSER;
  logic                               M_AXI_ARVALID;
  logic                               M_AXI_ARREADY;
  logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_RID;
  logic [C_M_AXI_DATA_WIDTH-1:0]      M_AXI_RDATA;
  logic [1:0]                         M_AXI_RRESP;
  logic                               M_AXI_RLAST;
  logic                               M_AXI_RVALID;
  logic                               M_AXI_RREADY;

  modport master (
    input  R0_REQ, R0_ADDR, R0_LEN, R0_RREADY,
    output R0_GNT, R0_RVALID, R0_RDATA, R0_RLAST, R0_DONE, R0_ERR,
    input  R1_REQ, R1_ADDR, R1_LEN, R1_RREADY,
    output R1_GNT, R1_RVALID, R1_RDATA, R1_RLAST, R1_DONE, R1_ERR,
    output M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
    output M_AXI_ARLOCK, M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARQOS, M_AXI_ARUSER,
    output M_AXI_ARVALID,
    input  M_AXI_ARREADY,
    input  M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
    output M_AXI_RREADY
  );

  modport slave (
    output R0_REQ, R0_ADDR, R0_LEN, R0_RREADY,
    input  R0_GNT, R0_RVALID, R0_RDATA, R0_RLAST, R0_DONE, R0_ERR,
    output R1_REQ, R1_ADDR, R1_LEN, R1_RREADY,
    input  R1_GNT, R1_RVALID, R1_RDATA, R1_RLAST, R1_DONE, R1_ERR,
    input  M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
    input  M_AXI_ARLOCK, M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARQOS, M_AXI_ARUSER,
    input  M_AXI_ARVALID,
    output M_AXI_ARREADY,
    output M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
    input  M_AXI_RREADY
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Round-robin share of one AXI4 read channel between instruction fetch (port 0)
// and data load (port 1); one burst outstanding, R beats routed to the granted port.
//
// state | meaning
// IDLE  | no burst outstanding, arbitrate on REQ
// ADDR  | AR presented and held until ARREADY
// DATA  | R beats routed to sel until the RLAST handshake
module axi_rd_arbiter #(
  parameter int C_M_AXI_ADDR_WIDTH      = 32,
  parameter int C_M_AXI_DATA_WIDTH      = 32,
  parameter int C_M_AXI_THREAD_ID_WIDTH = 1
) (
  input logic              CCLK,
  input logic              CRST,
  axi_rd_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t                             state, state_nxt;
  logic                               sel, sel_nxt;
  logic                               last_grant, last_grant_nxt;
  logic [C_M_AXI_ADDR_WIDTH-1:0]      araddr, araddr_nxt;
  logic [7:0]                         arlen, arlen_nxt;
  logic [C_M_AXI_THREAD_ID_WIDTH-1:0] arid, arid_nxt;
  logic                               arvalid, arvalid_nxt;
  logic [1:0]                         gnt, gnt_nxt;
  logic [1:0]                         done, done_nxt;
  logic [1:0]                         err, err_nxt;

  logic [1:0]                         req;
  logic                               win;
  logic                               in_data;
  logic                               sel_rready;
  logic                               beat_hs;
  logic [C_M_AXI_DATA_WIDTH-1:0]      rdata;

  assign req        = {bus.R1_REQ, bus.R0_REQ};
  // On contention the port that did not complete last goes next.
  assign win        = (&req) ? ~last_grant : req[1];
  assign in_data    = (state == DATA);
  assign sel_rready = sel ? bus.R1_RREADY : bus.R0_RREADY;
  assign beat_hs    = in_data & bus.M_AXI_RVALID & sel_rready;

  always_comb begin
    state_nxt      = state;
    sel_nxt        = sel;
    last_grant_nxt = last_grant;
    araddr_nxt     = araddr;
    arlen_nxt      = arlen;
    arid_nxt       = arid;
    arvalid_nxt    = arvalid;
    gnt_nxt        = 2'b00;
    done_nxt       = 2'b00;
    err_nxt        = err;

    unique case (state)
      IDLE: begin
        if (|req) begin
          sel_nxt       = win;
          araddr_nxt    = win ? bus.R1_ADDR : bus.R0_ADDR;
          arlen_nxt     = win ? bus.R1_LEN : bus.R0_LEN;
          arid_nxt      = '0;
          arid_nxt[0]   = win;
          arvalid_nxt   = 1'b1;
          gnt_nxt[win]  = 1'b1;
          state_nxt     = ADDR;
        end
      end
      ADDR: begin
        if (bus.M_AXI_ARREADY) begin
          arvalid_nxt = 1'b0;
          state_nxt   = DATA;
        end
      end
      DATA: begin
        if (beat_hs) begin
          if (bus.M_AXI_RRESP != 2'b00) begin
            err_nxt[sel] = 1'b1;
          end
          // RLAST alone ends the burst; beats are not counted against ARLEN.
          if (bus.M_AXI_RLAST) begin
            done_nxt[sel]  = 1'b1;
            last_grant_nxt = sel;
            state_nxt      = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CCLK or posedge CRST) begin
    if (CRST) begin
      state      <= IDLE;
      sel        <= 1'b0;
      last_grant <= 1'b1;
      araddr     <= '0;
      arlen      <= '0;
      arid       <= '0;
      arvalid    <= 1'b0;
      gnt        <= 2'b00;
      done       <= 2'b00;
      err        <= 2'b00;
    end else begin
      state      <= state_nxt;
      sel        <= sel_nxt;
      last_grant <= last_grant_nxt;
      araddr     <= araddr_nxt;
      arlen      <= arlen_nxt;
      arid       <= arid_nxt;
      arvalid    <= arvalid_nxt;
      gnt        <= gnt_nxt;
      done       <= done_nxt;
      err        <= err_nxt;
    end
  end

  assign bus.M_AXI_ARID    = arid;
  assign bus.M_AXI_ARADDR  = araddr;
  assign bus.M_AXI_ARLEN   = arlen;
  assign bus.M_AXI_ARSIZE  = 3'b010;
  assign bus.M_AXI_ARBURST = 2'b01;
  assign bus.M_AXI_ARLOCK  = 1'b0;
  assign bus.M_AXI_ARCACHE = 4'b0011;
  assign bus.M_AXI_ARPROT  = 3'b000;
  assign bus.M_AXI_ARQOS   = 4'b0000;
  assign bus.M_AXI_ARUSER  = 1'b0;
  assign bus.M_AXI_ARVALID = arvalid;

  // R routing is combinational so a beat costs no extra cycle on either side.
  assign bus.M_AXI_RREADY  = in_data & sel_rready;
  assign bus.R0_RVALID     = in_data & ~sel & bus.M_AXI_RVALID;
  assign bus.R1_RVALID     = in_data & sel & bus.M_AXI_RVALID;

  assign rdata             = bus.M_AXI_RDATA;
  assign bus.R0_RDATA      = rdata;
  assign bus.R1_RDATA      = rdata;
  assign bus.R0_RLAST      = bus.M_AXI_RLAST;
  assign bus.R1_RLAST      = bus.M_AXI_RLAST;

  assign bus.R0_GNT        = gnt[0];
  assign bus.R1_GNT        = gnt[1];
  assign bus.R0_DONE       = done[0];
  assign bus.R1_DONE       = done[1];
  assign bus.R0_ERR        = err[0];
  assign bus.R1_ERR        = err[1];

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all tracked by a burst-level reference model checked every cycle.
module tb_axi_rd_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 1;

  logic CCLK = 1'b0;
  logic CRST = 1'b1;
  always #5 CCLK = ~CCLK;

  axi_rd_arbiter_if #(
    .C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW), .C_M_AXI_THREAD_ID_WIDTH(IW)
  ) ifc ();

  axi_rd_arbiter #(
    .C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW), .C_M_AXI_THREAD_ID_WIDTH(IW)
  ) dut (
    .CCLK(CCLK),
    .CRST(CRST),
    .bus (ifc)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference model: one record describing the burst in flight, if any.
  bit          m_busy;
  bit          m_ar_ok;
  bit          m_port;
  bit          m_last;
  logic [AW-1:0] m_addr;
  logic [7:0]  m_len;
  bit [1:0]    m_gnt;
  bit [1:0]    m_done;
  bit [1:0]    m_err;

  function automatic void model_reset();
    m_busy  = 1'b0;
    m_ar_ok = 1'b0;
    m_port  = 1'b0;
    m_last  = 1'b1;
    m_addr  = '0;
    m_len   = '0;
    m_gnt   = '0;
    m_done  = '0;
    m_err   = '0;
  endfunction

  always @(negedge CCLK) begin
    bit in_data;
    bit sel_rr;
    bit w;
    if (CRST) model_reset();
    in_data = m_busy && m_ar_ok;
    sel_rr  = m_port ? ifc.R1_RREADY : ifc.R0_RREADY;
    chk("arvalid", 64'(ifc.M_AXI_ARVALID), 64'(m_busy && !m_ar_ok));
    chk("araddr",  64'(ifc.M_AXI_ARADDR),  64'(m_addr));
    chk("arlen",   64'(ifc.M_AXI_ARLEN),   64'(m_len));
    chk("arid",    64'(ifc.M_AXI_ARID),    64'(m_port));
    chk("rready",  64'(ifc.M_AXI_RREADY),  64'(in_data && sel_rr));
    chk("rvalid0", 64'(ifc.R0_RVALID),     64'(in_data && !m_port && ifc.M_AXI_RVALID));
    chk("rvalid1", 64'(ifc.R1_RVALID),     64'(in_data && m_port && ifc.M_AXI_RVALID));
    chk("rdata0",  64'(ifc.R0_RDATA),      64'(ifc.M_AXI_RDATA));
    chk("rdata1",  64'(ifc.R1_RDATA),      64'(ifc.M_AXI_RDATA));
    chk("rlast01", 64'({ifc.R1_RLAST, ifc.R0_RLAST}), 64'({2{ifc.M_AXI_RLAST}}));
    chk("gnt",     64'({ifc.R1_GNT, ifc.R0_GNT}),   64'(m_gnt));
    chk("done",    64'({ifc.R1_DONE, ifc.R0_DONE}), 64'(m_done));
    chk("err",     64'({ifc.R1_ERR, ifc.R0_ERR}),   64'(m_err));
    if (!CRST) begin
      m_gnt  = '0;
      m_done = '0;
      if (m_busy && !m_ar_ok) begin
        if (ifc.M_AXI_ARREADY) m_ar_ok = 1'b1;
      end else if (in_data) begin
        if (ifc.M_AXI_RVALID && sel_rr) begin
          if (ifc.M_AXI_RRESP != 2'b00) m_err[m_port] = 1'b1;
          if (ifc.M_AXI_RLAST) begin
            m_busy         = 1'b0;
            m_done[m_port] = 1'b1;
            m_last         = m_port;
          end
        end
      end else if (ifc.R0_REQ || ifc.R1_REQ) begin
        w        = (ifc.R0_REQ && ifc.R1_REQ) ? !m_last : ifc.R1_REQ;
        m_busy   = 1'b1;
        m_ar_ok  = 1'b0;
        m_port   = w;
        m_addr   = w ? ifc.R1_ADDR : ifc.R0_ADDR;
        m_len    = w ? ifc.R1_LEN : ifc.R0_LEN;
        m_gnt[w] = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge CCLK);
    #1;
  endtask

  task automatic do_reset();
    CRST = 1'b1;
    tick();
    tick();
    CRST = 1'b0;
  endtask

  task automatic wait_gnt(output int port);
    int g;
    g    = 0;
    port = -1;
    while (!(ifc.R0_GNT || ifc.R1_GNT) && g < 20) begin
      tick();
      g++;
    end
    if (ifc.R0_GNT) port = 0;
    else if (ifc.R1_GNT) port = 1;
    else chk("gnt_timeout", 64'(0), 64'(1));
  endtask

  // Acts as AXI slave for one burst; optionally toggles R1_RREADY every cycle.
  task automatic serve(input int nb, input logic [DW-1:0] base, input int bad,
                       input bit tog, output int hs_cnt);
    int i;
    int g;
    bit hs;
    i      = 0;
    g      = 0;
    hs_cnt = 0;
    ifc.M_AXI_ARREADY = 1'b1;
    while (!ifc.M_AXI_ARVALID && g < 20) begin
      tick();
      g++;
    end
    chk("ar_wait", 64'(ifc.M_AXI_ARVALID), 64'(1));
    tick();
    ifc.M_AXI_ARREADY = 1'b0;
    g = 0;
    while (i < nb && g < 100) begin
      ifc.M_AXI_RVALID = 1'b1;
      ifc.M_AXI_RDATA  = base + 32'(i);
      ifc.M_AXI_RLAST  = (i == nb - 1);
      ifc.M_AXI_RRESP  = (i == bad) ? 2'b10 : 2'b00;
      if (tog) ifc.R1_RREADY = ~ifc.R1_RREADY;
      #1;
      hs = ifc.M_AXI_RREADY;
      if (tog) chk("rready_mirror", 64'(ifc.M_AXI_RREADY), 64'(ifc.R1_RREADY));
      if (ifc.R0_RVALID && ifc.R0_RREADY) begin
        hs_cnt++;
        chk("beat_data0", 64'(ifc.R0_RDATA), 64'(base + 32'(i)));
      end
      if (ifc.R1_RVALID && ifc.R1_RREADY) begin
        hs_cnt++;
        chk("beat_data1", 64'(ifc.R1_RDATA), 64'(base + 32'(i)));
      end
      tick();
      if (hs) i++;
      g++;
    end
    chk("beat_count", 64'(i), 64'(nb));
    ifc.M_AXI_RVALID = 1'b0;
    ifc.M_AXI_RLAST  = 1'b0;
    ifc.M_AXI_RRESP  = 2'b00;
  endtask

  initial begin
    #1_000_000;
    chk("watchdog", 64'(0), 64'(1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    int p;
    int hc;
    int bl;
    bit ar_hs;
    bit r_hs;
    logic [7:0] ar_len;

    ifc.R0_REQ = 0; ifc.R0_ADDR = '0; ifc.R0_LEN = '0; ifc.R0_RREADY = 1;
    ifc.R1_REQ = 0; ifc.R1_ADDR = '0; ifc.R1_LEN = '0; ifc.R1_RREADY = 1;
    ifc.M_AXI_ARREADY = 0; ifc.M_AXI_RID = '0; ifc.M_AXI_RDATA = '0;
    ifc.M_AXI_RRESP = 2'b00; ifc.M_AXI_RLAST = 0; ifc.M_AXI_RVALID = 0;

    do_reset();
    chk("rst_arvalid", 64'(ifc.M_AXI_ARVALID), 64'(0));
    chk("rst_araddr",  64'(ifc.M_AXI_ARADDR),  64'(0));
    chk("rst_arid",    64'(ifc.M_AXI_ARID),    64'(0));
    chk("rst_err",     64'({ifc.R1_ERR, ifc.R0_ERR}), 64'(0));
    chk("arsize",      64'(ifc.M_AXI_ARSIZE),  64'(3'b010));
    chk("arburst",     64'(ifc.M_AXI_ARBURST), 64'(2'b01));
    chk("arcache",     64'(ifc.M_AXI_ARCACHE), 64'(4'b0011));

    // single port-0 burst
    ifc.R0_REQ = 1; ifc.R0_ADDR = 32'h0000_1000; ifc.R0_LEN = 8'd3; ifc.M_AXI_ARREADY = 1;
    tick();
    chk("t1_gnt0",    64'(ifc.R0_GNT),        64'(1));
    chk("t1_arvalid", 64'(ifc.M_AXI_ARVALID), 64'(1));
    chk("t1_arid",    64'(ifc.M_AXI_ARID),    64'(0));
    chk("t1_araddr",  64'(ifc.M_AXI_ARADDR),  64'(32'h1000));
    chk("t1_arlen",   64'(ifc.M_AXI_ARLEN),   64'(3));
    ifc.R0_REQ = 0;
    serve(4, 32'hA0, -1, 1'b0, hc);
    chk("t1_beats", 64'(hc), 64'(4));
    chk("t1_done0", 64'(ifc.R0_DONE), 64'(1));
    chk("t1_done1", 64'(ifc.R1_DONE), 64'(0));
    tick();
    chk("t1_done0_pulse", 64'(ifc.R0_DONE), 64'(0));
    chk("t1_err0",        64'(ifc.R0_ERR),  64'(0));

    // contention from reset alternates 0,1,0,1
    do_reset();
    ifc.R0_REQ = 1; ifc.R0_ADDR = 32'h100; ifc.R0_LEN = 0;
    ifc.R1_REQ = 1; ifc.R1_ADDR = 32'h200; ifc.R1_LEN = 0;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(p);
      chk("t2_order",  64'(p), 64'(k % 2));
      chk("t2_araddr", 64'(ifc.M_AXI_ARADDR), (k % 2) ? 64'(32'h200) : 64'(32'h100));
      serve(1, 32'hB0 + 32'(k), -1, 1'b0, hc);
    end
    ifc.R0_REQ = 0; ifc.R1_REQ = 0;

    // ARREADY held low: AR stable, R channel ignored
    ifc.R1_REQ = 1; ifc.R1_ADDR = 32'h3000; ifc.R1_LEN = 8'd2;
    wait_gnt(p);
    chk("t3_port", 64'(p), 64'(1));
    ifc.R1_REQ = 0;
    ifc.M_AXI_RVALID = 1; ifc.M_AXI_RDATA = 32'hDEAD; ifc.M_AXI_RLAST = 1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t3_arvalid", 64'(ifc.M_AXI_ARVALID), 64'(1));
      chk("t3_araddr",  64'(ifc.M_AXI_ARADDR),  64'(32'h3000));
      chk("t3_arlen",   64'(ifc.M_AXI_ARLEN),   64'(2));
      chk("t3_arid",    64'(ifc.M_AXI_ARID),    64'(1));
      chk("t3_gnt1",    64'(ifc.R1_GNT),        64'(0));
      chk("t3_rready",  64'(ifc.M_AXI_RREADY),  64'(0));
    end
    ifc.M_AXI_RVALID = 0; ifc.M_AXI_RLAST = 0;
    serve(3, 32'hC0, -1, 1'b0, hc);
    chk("t3_done1", 64'(ifc.R1_DONE), 64'(1));

    // port-1 burst of 8 with toggling RREADY
    ifc.R1_RREADY = 0;
    ifc.R1_REQ = 1; ifc.R1_ADDR = 32'h4000; ifc.R1_LEN = 8'd7;
    wait_gnt(p);
    chk("t4_port", 64'(p), 64'(1));
    ifc.R1_REQ = 0;
    serve(8, 32'hD0, -1, 1'b1, hc);
    chk("t4_hs",    64'(hc), 64'(8));
    chk("t4_done1", 64'(ifc.R1_DONE), 64'(1));
    ifc.R1_RREADY = 1;

    // sticky error on port 1
    ifc.R1_REQ = 1; ifc.R1_ADDR = 32'h5000; ifc.R1_LEN = 8'd3;
    wait_gnt(p);
    ifc.R1_REQ = 0;
    serve(4, 32'hE0, 2, 1'b0, hc);
    chk("t5_err1", 64'(ifc.R1_ERR), 64'(1));
    chk("t5_err0", 64'(ifc.R0_ERR), 64'(0));
    ifc.R1_REQ = 1; ifc.R1_LEN = 8'd0;
    wait_gnt(p);
    ifc.R1_REQ = 0;
    serve(1, 32'hE8, -1, 1'b0, hc);
    ifc.R0_REQ = 1; ifc.R0_ADDR = 32'h6000; ifc.R0_LEN = 8'd1;
    wait_gnt(p);
    ifc.R0_REQ = 0;
    serve(2, 32'hEC, -1, 1'b0, hc);
    chk("t5_err1_sticky", 64'(ifc.R1_ERR), 64'(1));
    chk("t5_err0_clean",  64'(ifc.R0_ERR), 64'(0));
    CRST = 1;
    #1;
    chk("t5_err1_clr", 64'(ifc.R1_ERR), 64'(0));
    tick();
    CRST = 0;

    // asynchronous reset in DATA
    ifc.R0_REQ = 1; ifc.R0_ADDR = 32'h7000; ifc.R0_LEN = 8'd3; ifc.M_AXI_ARREADY = 1;
    wait_gnt(p);
    ifc.R0_REQ = 0;
    tick();
    ifc.M_AXI_RVALID = 1; ifc.M_AXI_RDATA = 32'hF0; ifc.M_AXI_RLAST = 0;
    #1;
    chk("t6_rready_pre", 64'(ifc.M_AXI_RREADY), 64'(1));
    #1;
    CRST = 1;
    #1;
    chk("t6_arvalid", 64'(ifc.M_AXI_ARVALID), 64'(0));
    chk("t6_rready",  64'(ifc.M_AXI_RREADY),  64'(0));
    chk("t6_rvalid0", 64'(ifc.R0_RVALID),     64'(0));
    chk("t6_gnt",     64'({ifc.R1_GNT, ifc.R0_GNT}),   64'(0));
    chk("t6_done",    64'({ifc.R1_DONE, ifc.R0_DONE}), 64'(0));
    ifc.M_AXI_RVALID = 0; ifc.M_AXI_ARREADY = 0;
    tick();
    CRST = 0;
    ifc.R0_REQ = 1; ifc.R0_ADDR = 32'h8000; ifc.R0_LEN = 8'd1;
    wait_gnt(p);
    chk("t6_port",   64'(p), 64'(0));
    chk("t6_araddr", 64'(ifc.M_AXI_ARADDR), 64'(32'h8000));
    ifc.R0_REQ = 0;
    serve(2, 32'h90, -1, 1'b0, hc);
    chk("t6_done0", 64'(ifc.R0_DONE), 64'(1));

    // randomized traffic
    bl = 0;
    for (int c = 0; c < 3000; c++) begin
      if (ifc.R0_REQ && ifc.R0_GNT) ifc.R0_REQ = 0;
      else if (!ifc.R0_REQ && $urandom_range(3) == 0) begin
        ifc.R0_REQ  = 1;
        ifc.R0_ADDR = $urandom & 32'hFFFF_FFFC;
        ifc.R0_LEN  = 8'($urandom_range(5));
      end
      if (ifc.R1_REQ && ifc.R1_GNT) ifc.R1_REQ = 0;
      else if (!ifc.R1_REQ && $urandom_range(3) == 0) begin
        ifc.R1_REQ  = 1;
        ifc.R1_ADDR = $urandom & 32'hFFFF_FFFC;
        ifc.R1_LEN  = 8'($urandom_range(5));
      end
      ifc.R0_RREADY     = ($urandom_range(3) != 0);
      ifc.R1_RREADY     = ($urandom_range(3) != 0);
      ifc.M_AXI_ARREADY = 1'($urandom_range(1));
      if (!ifc.M_AXI_RVALID && bl > 0 && $urandom_range(3) != 0) begin
        ifc.M_AXI_RVALID = 1;
        ifc.M_AXI_RDATA  = $urandom;
        ifc.M_AXI_RLAST  = (bl == 1);
        ifc.M_AXI_RRESP  = ($urandom_range(15) == 0) ? 2'b10 : 2'b00;
      end
      @(negedge CCLK);
      ar_hs  = ifc.M_AXI_ARVALID && ifc.M_AXI_ARREADY;
      ar_len = ifc.M_AXI_ARLEN;
      r_hs   = ifc.M_AXI_RVALID && ifc.M_AXI_RREADY;
      tick();
      if (ar_hs) bl = int'(ar_len) + 1;
      if (r_hs) begin
        bl--;
        ifc.M_AXI_RVALID = 0;
        ifc.M_AXI_RLAST  = 0;
        ifc.M_AXI_RRESP  = 2'b00;
      end
    end
    ifc.R0_REQ = 0; ifc.R1_REQ = 0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
